// File: rtl/genius_pkg.sv
// Shared types and helpers for the Genius game blocks.
// Holds the FSM state enum, code/LED widths, LED decode and LFSR taps.
package genius_pkg;

  localparam int CODE_W = 2;
  localparam int LED_W  = 4;

  // Right-shift Fibonacci taps for x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_ON,
    ST_OFF,
    ST_DONE
  } state_e;

  function automatic logic [LED_W-1:0] onehot4(
    input logic [CODE_W-1:0] c
  );
    logic [LED_W-1:0] r;
    r    = '0;
    r[c] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/genius_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, loaded with SEED on reset.
// Ports: CLOCK, reset (async, active-high), state_o (current state).
module genius_lfsr16
  import genius_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        CLOCK,
  input  logic        reset,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q;
  logic        fb;

  assign fb = ^(lfsr_q & LFSR_TAPS);

  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) lfsr_q <= SEED;
    else       lfsr_q <= {fb, lfsr_q[15:1]};
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/genius_seq_player.sv
// Genius sequence source: fills, stores and plays the colour sequence.
// Ports: CLOCK, reset, new_seq, start, level, rd_idx in;
//        rd_code, leds, busy, end_FPGA out.
module genius_seq_player
  import genius_pkg::*;
#(
  parameter int          SEQ_MAX   = 16,
  parameter int          ON_TICKS  = 25000000,
  parameter int          OFF_TICKS = 12500000,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic                         CLOCK,
  input  logic                         reset,
  input  logic                         new_seq,
  input  logic                         start,
  input  logic [$clog2(SEQ_MAX+1)-1:0] level,
  input  logic [$clog2(SEQ_MAX)-1:0]   rd_idx,
  output logic [CODE_W-1:0]            rd_code,
  output logic [LED_W-1:0]             leds,
  output logic                         busy,
  output logic                         end_FPGA
);

  localparam int IDX_W = $clog2(SEQ_MAX);
  localparam int LVL_W = $clog2(SEQ_MAX+1);
  localparam int MAXT  =
    (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int CNT_W = $clog2(MAXT+1);

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_TICKS-1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_TICKS-1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SEQ_MAX-1);
  localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(SEQ_MAX);

  state_e            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [LVL_W-1:0]  len_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CODE_W-1:0] mem_q [SEQ_MAX];
  logic [LED_W-1:0]  leds_q;
  logic              busy_q;
  logic              end_q;

  logic [15:0]       lfsr_w;
  logic [13:0]       lfsr_unused;
  logic [CODE_W-1:0] rnd_w;

  logic [LVL_W-1:0]  len_d;
  logic [IDX_W-1:0]  idx_d;
  logic              last_w;

  genius_lfsr16 #(
    .SEED (SEED)
  ) u_lfsr (
    .CLOCK   (CLOCK),
    .reset   (reset),
    .state_o (lfsr_w)
  );

  assign {lfsr_unused, rnd_w} = lfsr_w;

  // Playback length saturates at the storage depth
  assign len_d  = (level > LVL_MAX) ? LVL_MAX : level;
  assign idx_d  = idx_q + IDX_W'(1);
  assign last_w = (LVL_W'(idx_q) == len_q - LVL_W'(1));

  assign rd_code  = mem_q[rd_idx];
  assign leds     = leds_q;
  assign busy     = busy_q;
  assign end_FPGA = end_q;

  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      leds_q  <= '0;
      busy_q  <= 1'b0;
      end_q   <= 1'b0;
      for (int i = 0; i < SEQ_MAX; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      end_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          // new_seq wins; a simultaneous start is dropped
          if (new_seq) begin
            state_q <= ST_FILL;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end else if (start) begin
            idx_q  <= '0;
            len_q  <= len_d;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (len_d == '0) begin
              state_q <= ST_DONE;
              end_q   <= 1'b1;
            end else begin
              state_q <= ST_ON;
              leds_q  <= onehot4(mem_q[0]);
            end
          end
        end
        ST_FILL: begin
          mem_q[idx_q] <= rnd_w;
          idx_q        <= idx_d;
          if (idx_q == IDX_LAST) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
          end
        end
        ST_ON: begin
          if (cnt_q == ON_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_OFF;
            leds_q  <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_OFF: begin
          if (cnt_q == OFF_LAST) begin
            cnt_q <= '0;
            if (last_w) begin
              state_q <= ST_DONE;
              end_q   <= 1'b1;
            end else begin
              idx_q   <= idx_d;
              state_q <= ST_ON;
              leds_q  <= onehot4(mem_q[idx_d]);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          leds_q  <= '0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          leds_q  <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_genius_seq_player.sv
// Directed bench for genius_seq_player with a small LFSR model.
// Ports: none; drives DUT with SEQ_MAX=4, ON=3, OFF=2.
`timescale 1ns/1ps
module tb_genius_seq_player;

  localparam int          SEQ_MAX = 4;
  localparam int          ON_T    = 3;
  localparam int          OFF_T   = 2;
  localparam logic [15:0] SEED    = 16'hACE1;

  typedef struct {
    logic [2:0] lv;
    int         endc;
    int         hold;
    int         quiet;
  } scen_t;

  typedef struct {
    logic [1:0] idx;
    logic [1:0] code;
  } rd_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       new_seq = 1'b0;
  logic       start = 1'b0;
  logic [2:0] level = '0;
  logic [1:0] rd_idx = '0;
  logic [1:0] rd_code;
  logic [3:0] leds;
  logic       busy;
  logic       endp;

  int checks = 0;
  int errors = 0;

  logic [15:0] m;
  logic [1:0]  exp_mem [4];

  always #10 clk = ~clk;

  // Reference LFSR: x^16+x^14+x^13+x^11+1, right-shifting
  always @(posedge clk or posedge rst) begin
    if (rst) m <= SEED;
    else     m <= {m[0] ^ m[2] ^ m[3] ^ m[5], m[15:1]};
  end

  genius_seq_player #(
    .SEQ_MAX   (SEQ_MAX),
    .ON_TICKS  (ON_T),
    .OFF_TICKS (OFF_T),
    .SEED      (SEED)
  ) dut (
    .CLOCK    (clk),
    .reset    (rst),
    .new_seq  (new_seq),
    .start    (start),
    .level    (level),
    .rd_idx   (rd_idx),
    .rd_code  (rd_code),
    .leds     (leds),
    .busy     (busy),
    .end_FPGA (endp)
  );

  task automatic chk(string nm, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] oh(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction

  task automatic check_mem(string nm);
    for (int k = 0; k < SEQ_MAX; k++) begin
      rd_idx = 2'(k);
      #1;
      chk(nm, 32'(rd_code), 32'(exp_mem[k]));
    end
  endtask

  // One new_seq request; entry k is the model value after edge k
  task automatic fill_seq(bit with_start);
    new_seq = 1'b1;
    start   = with_start;
    @(posedge clk);
    #1;
    new_seq = 1'b0;
    start   = 1'b0;
    for (int k = 0; k < SEQ_MAX; k++) begin
      exp_mem[k] = m[1:0];
      chk("fill_busy", 32'(busy), 32'd1);
      tick();
    end
    chk("fill_idle", 32'(busy), 32'd0);
    check_mem("fill_rd");
    for (int q = 0; q < 6; q++) begin
      chk("fill_leds", 32'(leds), 32'd0);
      chk("fill_end", 32'(endp), 32'd0);
      tick();
    end
  endtask

  // Cycle c=1 is the cycle right after the start sample
  task automatic play(scen_t s);
    logic [3:0] el;
    logic       eb;
    logic       ee;
    int         k;
    int         ph;
    level = s.lv;
    start = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 1; c <= s.endc + 1 + s.quiet; c++) begin
      if (c > s.hold) start = 1'b0;
      if (c < s.endc) begin
        k  = (c - 1) / (ON_T + OFF_T);
        ph = (c - 1) % (ON_T + OFF_T);
        el = (ph < ON_T) ? oh(exp_mem[k]) : 4'b0000;
        eb = 1'b1;
        ee = 1'b0;
      end else if (c == s.endc) begin
        el = 4'b0000;
        eb = 1'b1;
        ee = 1'b1;
      end else begin
        el = 4'b0000;
        eb = 1'b0;
        ee = 1'b0;
      end
      chk("play_leds", 32'(leds), 32'(el));
      chk("play_busy", 32'(busy), 32'(eb));
      chk("play_end", 32'(endp), 32'(ee));
      tick();
    end
  endtask

  scen_t tbl [5];
  rd_t   rdt [4];
  scen_t held;
  scen_t one;

  initial begin
    // level is 3 bits wide, so 7 is the largest over-range value
    tbl[0] = '{lv: 3'd3, endc: 16, hold: 0, quiet: 2};
    tbl[1] = '{lv: 3'd0, endc: 1,  hold: 0, quiet: 2};
    tbl[2] = '{lv: 3'd7, endc: 21, hold: 0, quiet: 2};
    tbl[3] = '{lv: 3'd4, endc: 21, hold: 0, quiet: 2};
    tbl[4] = '{lv: 3'd1, endc: 6,  hold: 0, quiet: 2};
    for (int i = 0; i < 4; i++) begin
      rdt[i] = '{idx: 2'(i), code: 2'd0};
    end
    held = '{lv: 3'd1, endc: 6, hold: 3, quiet: 6};
    one  = '{lv: 3'd1, endc: 6, hold: 0, quiet: 2};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_leds", 32'(leds), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_end", 32'(endp), 32'd0);
    for (int i = 0; i < 4; i++) begin
      rd_idx = rdt[i].idx;
      #1;
      chk("rst_rd", 32'(rd_code), 32'(rdt[i].code));
    end
    @(negedge clk);
    rst = 1'b0;
    tick();

    fill_seq(1'b0);
    for (int i = 0; i < 5; i++) begin
      play(tbl[i]);
    end

    // new_seq and start together: fill only, no playback
    fill_seq(1'b1);

    // start held through ON: single playback, single pulse
    play(held);

    // reset while an entry is lit
    level = 3'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    tick();
    chk("mid_on_leds", 32'(leds), 32'(oh(exp_mem[0])));
    #3;
    rst = 1'b1;
    #1;
    chk("mr_leds", 32'(leds), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_end", 32'(endp), 32'd0);
    for (int k = 0; k < SEQ_MAX; k++) exp_mem[k] = 2'd0;
    check_mem("mr_rd");
    @(negedge clk);
    rst = 1'b0;
    tick();
    play(one);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
